rv_mem_arb: RTL and testbench

- Arbitrates the core's single external memory bus between two requesters: instruction fetch (read-only) and the memory stage load/store (read/write).
- Sits between the fetch and memory stages and the Wishbone-classic master port.
- Sequences each bus cycle and times out hung slaves.
- Enforces data priority, with a bounded fetch-starvation limit.

---
 rtl/rv_mem_arb.sv | 181 ++++++++++++++++++
 tb/tb_rv_mem_arb.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_arb.sv
// Two-requester Wishbone-classic arbiter: instruction fetch (read-only) versus
// load/store, with data priority, bounded fetch starvation and a bus timeout.
module rv_mem_arb #(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16,
   parameter int D_MAX   = 4
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_f_req,
   input  logic [ADDR_W-1:0]   i_f_addr,
   output logic                o_f_ack,
   output logic                o_f_err,
   output logic [XLEN-1:0]     o_f_rdata,
   input  logic                i_d_req,
   input  logic                i_d_we,
   input  logic [ADDR_W-1:0]   i_d_addr,
   input  logic [XLEN-1:0]     i_d_wdata,
   input  logic [XLEN/8-1:0]   i_d_sel,
   output logic                o_d_ack,
   output logic                o_d_err,
   output logic [XLEN-1:0]     o_d_rdata,
   output logic                o_wb_cyc,
   output logic                o_wb_stb,
   output logic                o_wb_we,
   output logic [ADDR_W-1:0]   o_wb_adr,
   output logic [XLEN-1:0]     o_wb_dat,
   output logic [XLEN/8-1:0]   o_wb_sel,
   input  logic [XLEN-1:0]     i_wb_dat,
   input  logic                i_wb_ack,
   input  logic                i_wb_err
);

   localparam int SW = $clog2(D_MAX + 1);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUS_F = 2'd1,
      BUS_D = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t              state_q;
   logic [SW-1:0]       starv_q;
   logic [TW-1:0]       tmo_q;
   logic                gnt_d_q;
   logic                cyc_q;
   logic                we_q;
   logic [ADDR_W-1:0]   adr_q;
   logic [XLEN-1:0]     dat_q;
   logic [XLEN/8-1:0]   sel_q;
   logic                f_ack_q;
   logic                f_err_q;
   logic [XLEN-1:0]     f_rdata_q;
   logic                d_ack_q;
   logic                d_err_q;
   logic [XLEN-1:0]     d_rdata_q;

   logic starved_s;
   logic pick_d_s;
   logic pick_f_s;
   logic bus_done_s;
   logic tmo_hit_s;

   // Fetch wins a contested slot only once data has taken D_MAX slots in a row.
   assign starved_s  = (int'(starv_q) == D_MAX);
   assign pick_d_s   = i_d_req && !(i_f_req && starved_s);
   assign pick_f_s   = i_f_req && !pick_d_s;
   assign bus_done_s = i_wb_ack || i_wb_err;
   assign tmo_hit_s  = (TIMEOUT > 0) && (int'(tmo_q) >= TIMEOUT - 1);

   // Arbitration, bus sequencing and response FSM with registered outputs.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= IDLE;
         starv_q   <= '0;
         tmo_q     <= '0;
         gnt_d_q   <= 1'b0;
         cyc_q     <= 1'b0;
         we_q      <= 1'b0;
         adr_q     <= '0;
         dat_q     <= '0;
         sel_q     <= '0;
         f_ack_q   <= 1'b0;
         f_err_q   <= 1'b0;
         f_rdata_q <= '0;
         d_ack_q   <= 1'b0;
         d_err_q   <= 1'b0;
         d_rdata_q <= '0;
      end else begin
         f_ack_q <= 1'b0;
         f_err_q <= 1'b0;
         d_ack_q <= 1'b0;
         d_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!i_f_req) begin
                  starv_q <= '0;
               end
               if (pick_d_s) begin
                  if (i_f_req) begin
                     starv_q <= starv_q + SW'(1);
                  end
                  state_q <= BUS_D;
                  gnt_d_q <= 1'b1;
                  cyc_q   <= 1'b1;
                  we_q    <= i_d_we;
                  adr_q   <= i_d_addr;
                  dat_q   <= i_d_wdata;
                  sel_q   <= i_d_sel;
                  tmo_q   <= '0;
               end else if (pick_f_s) begin
                  starv_q <= '0;
                  state_q <= BUS_F;
                  gnt_d_q <= 1'b0;
                  cyc_q   <= 1'b1;
                  we_q    <= 1'b0;
                  adr_q   <= i_f_addr;
                  dat_q   <= '0;
                  sel_q   <= '1;
                  tmo_q   <= '0;
               end else begin
                  state_q <= IDLE;
               end
            end
            BUS_F, BUS_D: begin
               if (bus_done_s) begin
                  cyc_q   <= 1'b0;
                  state_q <= RESP;
                  if (gnt_d_q) begin
                     d_ack_q   <= 1'b1;
                     d_err_q   <= i_wb_err;
                     d_rdata_q <= i_wb_dat;
                  end else begin
                     f_ack_q   <= 1'b1;
                     f_err_q   <= i_wb_err;
                     f_rdata_q <= i_wb_dat;
                  end
               end else if (tmo_hit_s) begin
                  cyc_q   <= 1'b0;
                  state_q <= RESP;
                  if (gnt_d_q) begin
                     d_ack_q   <= 1'b1;
                     d_err_q   <= 1'b1;
                     d_rdata_q <= '0;
                  end else begin
                     f_ack_q   <= 1'b1;
                     f_err_q   <= 1'b1;
                     f_rdata_q <= '0;
                  end
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               cyc_q   <= 1'b0;
            end
         endcase
      end
   end

   assign o_f_ack   = f_ack_q;
   assign o_f_err   = f_err_q;
   assign o_f_rdata = f_rdata_q;
   assign o_d_ack   = d_ack_q;
   assign o_d_err   = d_err_q;
   assign o_d_rdata = d_rdata_q;
   assign o_wb_cyc  = cyc_q;
   assign o_wb_stb  = cyc_q;
   assign o_wb_we   = we_q;
   assign o_wb_adr  = adr_q;
   assign o_wb_dat  = dat_q;
   assign o_wb_sel  = sel_q;

endmodule

// File: tb/tb_rv_mem_arb.sv
// Bench for rv_mem_arb: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_rv_mem_arb;
   localparam int XLEN = 32, ADDR_W = 32, TIMEOUT = 16, D_MAX = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;
   logic f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [31:0] f_addr = 32'd0, d_addr = 32'd0, d_wdata = 32'd0, wb_dat = 32'd0;
   logic [3:0] d_sel = 4'd0;
   logic wb_ack = 1'b0, wb_err = 1'b0;
   logic o_f_ack, o_f_err, o_d_ack, o_d_err, o_wb_cyc, o_wb_stb, o_wb_we;
   logic [31:0] o_f_rdata, o_d_rdata, o_wb_adr, o_wb_dat;
   logic [3:0] o_wb_sel;

   rv_mem_arb #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .D_MAX(D_MAX)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_f_req(f_req), .i_f_addr(f_addr),
      .o_f_ack(o_f_ack), .o_f_err(o_f_err), .o_f_rdata(o_f_rdata),
      .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata), .i_d_sel(d_sel),
      .o_d_ack(o_d_ack), .o_d_err(o_d_err), .o_d_rdata(o_d_rdata),
      .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_adr(o_wb_adr),
      .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
      .i_wb_dat(wb_dat), .i_wb_ack(wb_ack), .i_wb_err(wb_err)
   );

   int n_chk = 0, n_fail = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: phase 0 = free, 1 = bus transfer, 2 = reporting.
   int m_ph = 0, m_wait = 0, m_starv = 0;
   bit m_isd = 1'b0;
   logic [31:0] m_adr = 32'd0, m_dat = 32'd0;
   logic m_we = 1'b0;
   logic [3:0] m_sel = 4'd0;
   logic e_fack = 1'b0, e_ferr = 1'b0, e_dack = 1'b0, e_derr = 1'b0;
   logic [31:0] e_frd = 32'd0, e_drd = 32'd0;
   bit gq[$];

   task automatic m_complete(input logic err, input logic [31:0] dat);
      m_ph = 2;
      if (m_isd) begin
         e_dack = 1'b1; e_derr = err; e_drd = dat;
      end else begin
         e_fack = 1'b1; e_ferr = err; e_frd = dat;
      end
   endtask

   task automatic model_step();
      bit gd;
      e_fack = 1'b0; e_ferr = 1'b0; e_dack = 1'b0; e_derr = 1'b0;
      if (rst) begin
         m_ph = 0; m_starv = 0; m_wait = 0;
         e_frd = 32'd0; e_drd = 32'd0;
         return;
      end
      if (m_ph == 0) begin
         if (!f_req) m_starv = 0;
         gd = d_req && !(f_req && m_starv == D_MAX);
         if (gd || f_req) begin
            m_ph = 1; m_wait = 0; m_isd = gd;
            gq.push_back(gd);
            if (gd) begin
               m_adr = d_addr; m_we = d_we; m_dat = d_wdata; m_sel = d_sel;
               if (f_req) m_starv++;
            end else begin
               m_adr = f_addr; m_we = 1'b0; m_sel = 4'hF; m_starv = 0;
            end
         end
      end else if (m_ph == 1) begin
         m_wait++;
         if (wb_ack || wb_err) m_complete(wb_err, wb_dat);
         else if (TIMEOUT > 0 && m_wait == TIMEOUT) m_complete(1'b1, 32'd0);
      end else begin
         m_ph = 0;
      end
   endtask

   task automatic compare();
      chk1("cyc", o_wb_cyc, m_ph == 1);
      chk1("stb", o_wb_stb, m_ph == 1);
      if (m_ph == 1) begin
         chk32("adr", o_wb_adr, m_adr);
         chk1("we", o_wb_we, m_we);
         chk32("sel", 32'(o_wb_sel), 32'(m_sel));
         if (m_we) chk32("wdat", o_wb_dat, m_dat);
      end
      chk1("f_ack", o_f_ack, e_fack);
      chk1("d_ack", o_d_ack, e_dack);
      if (e_fack) chk1("f_err", o_f_err, e_ferr);
      if (e_dack) chk1("d_err", o_d_err, e_derr);
      chk32("f_rdata", o_f_rdata, e_frd);
      chk32("d_rdata", o_d_rdata, e_drd);
   endtask

   // Stimulus: slave behaviour and, in random mode, the two requesters.
   bit rnd = 1'b0;
   int dir_ws = 0, dir_kind = 0, ws = 0, kind = 0;
   logic [31:0] dir_dat = 32'd0;

   task automatic drive();
      int r;
      if (m_ph == 1 && m_wait == 0) begin
         if (rnd) begin
            r = $urandom_range(0, 9);
            ws = (r < 6) ? r % 4 : (r == 6) ? 15 : (r == 7) ? 16 : 1000;
            r = $urandom_range(0, 7);
            kind = (r < 5) ? 0 : (r < 7) ? 1 : 2;
         end else begin
            ws = dir_ws; kind = dir_kind;
         end
      end
      if (m_ph == 1 && m_wait == ws) begin
         wb_ack = (kind != 1); wb_err = (kind != 0);
      end else if (m_ph == 1 || !rnd) begin
         wb_ack = 1'b0; wb_err = 1'b0;
      end else begin
         wb_ack = 1'($urandom); wb_err = ($urandom_range(0, 3) == 0);
      end
      wb_dat = rnd ? $urandom : dir_dat;
      if (rnd) begin
         if (!f_req || e_fack) begin
            f_req = ($urandom_range(0, 3) != 0); f_addr = $urandom;
         end
         if (!d_req || e_dack) begin
            d_req = ($urandom_range(0, 2) != 0); d_we = 1'($urandom);
            d_addr = $urandom; d_wdata = $urandom; d_sel = 4'($urandom);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
      drive();
   endtask

   task automatic run_txn(input bit drop, output int ncyc);
      bit got;
      got = 1'b0; ncyc = 0;
      for (int i = 0; i < 60 && !got; i++) begin
         tick();
         if (o_wb_cyc) ncyc++;
         if (o_f_ack || o_d_ack) begin
            got = 1'b1;
            if (drop && o_f_ack) f_req = 1'b0;
            if (drop && o_d_ack) d_req = 1'b0;
         end
      end
      chk1("ack_seen", got, 1'b1);
   endtask

   task automatic single_fetch();
      int n;
      f_req = 1'b1; f_addr = 32'h100; dir_ws = 0; dir_kind = 0; dir_dat = 32'h13;
      tick();
      chk1("sf_cyc1", o_wb_cyc, 1'b1);
      chk32("sf_adr", o_wb_adr, 32'h100);
      run_txn(1'b1, n);
      chk32("sf_ncyc", 32'(n), 32'd0);
      chk1("sf_ack", o_f_ack, 1'b1);
      chk1("sf_err", o_f_err, 1'b0);
      chk32("sf_rdata", o_f_rdata, 32'h13);
      chk1("sf_dack", o_d_ack, 1'b0);
   endtask

   bit exp_order[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

   initial begin
      int n;
      tick();
      tick();
      chk1("rst_cyc", o_wb_cyc, 1'b0);
      chk32("rst_frd", o_f_rdata, 32'd0);
      chk1("rst_dack", o_d_ack, 1'b0);
      rst = 1'b0;
      tick();

      single_fetch();
      tick();

      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_sel = 4'b0011;
      dir_ws = 3; dir_kind = 0;
      run_txn(1'b1, n);
      chk32("wr_ncyc", 32'(n), 32'd4);
      chk1("wr_dack", o_d_ack, 1'b1);
      chk1("wr_derr", o_d_err, 1'b0);
      tick();

      gq.delete();
      f_req = 1'b1; f_addr = 32'h400; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800;
      dir_ws = 0;
      for (int k = 0; k < 10; k++) run_txn(1'b0, n);
      chk32("order_len", 32'(gq.size()), 32'd10);
      for (int k = 0; k < 10 && k < gq.size(); k++) chk1($sformatf("order_%0d", k), gq[k], exp_order[k]);
      f_req = 1'b0; d_req = 1'b0;
      tick();
      tick();

      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; dir_ws = 1000;
      run_txn(1'b1, n);
      chk32("to_ncyc", 32'(n), 32'd16);
      chk1("to_dack", o_d_ack, 1'b1);
      chk1("to_derr", o_d_err, 1'b1);
      chk32("to_drd", o_d_rdata, 32'd0);
      tick();

      f_req = 1'b1; f_addr = 32'h300; dir_ws = 0; dir_kind = 2; dir_dat = 32'h55;
      run_txn(1'b1, n);
      chk1("both_fack", o_f_ack, 1'b1);
      chk1("both_ferr", o_f_err, 1'b1);
      dir_kind = 0;
      tick();

      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h5000; d_wdata = 32'h1234; d_sel = 4'hF; dir_ws = 1000;
      tick(); tick(); tick();
      chk1("mr_cyc_pre", o_wb_cyc, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk1("mr_cyc_drop", o_wb_cyc, 1'b0);
      chk1("mr_dack", o_d_ack, 1'b0);
      d_req = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      single_fetch();
      tick();

      rnd = 1'b1;
      for (int k = 0; k < 4000; k++) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
